// File: rtl/mr_operand_mul.sv
// mr_operand_mul
//   Producer front end of the modular-reduction unit. It accepts coefficient
//   pairs tagged with a Kyber/Dilithium mode. Each operand is masked to the
//   mode's coefficient width, and the full-width unsigned product d = a * b is
//   delivered through a 2-stage valid/ready pipeline (S1: masked operands,
//   S2: product).
//
//   Optional feature macro: MRMUL_RANGE_CHK_EN
//     When defined, S1 flags operands that are >= q for the tagged mode. In
//     Kyber mode, any nonzero bit above the 12-bit coefficient also sets the
//     flag. The flag travels with the product to out_err, and the product
//     itself is unchanged. When the macro is undefined, out_err and its
//     pipeline bits do not exist.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   pipeline can take a pair this cycle (combinational from out_ready)
//   in_mode    0: Kyber (q=3329), 1: Dilithium (q=8380417)
//   in_a/in_b  operands, AW bits
//   out_valid  product valid
//   out_ready  downstream accepts
//   out_mode   mode tag travelling with the product
//   out_d      product, DW bits
//   out_err    operand range violation (MRMUL_RANGE_CHK_EN only)

module mr_operand_mul #(
    parameter int DW = 46,
    parameter int AW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_mode,
    output logic [DW-1:0] out_d
`ifdef MRMUL_RANGE_CHK_EN
    ,
    output logic          out_err
`endif
);

    // Kyber coefficients are 12 bits wide.
    localparam int KW = 12;

    // Handshake / advance controls
    logic          w_s2_adv;
    logic          w_s1_adv;
    logic          w_acc;

    // Masked operands
    logic [AW-1:0] w_a;
    logic [AW-1:0] w_b;
    logic [DW-1:0] w_prod;

    // Stage 1: masked operands + mode
    logic          r_s1_v;
    logic          r_s1_mode;
    logic [AW-1:0] r_s1_a;
    logic [AW-1:0] r_s1_b;

    // Stage 2: product + mode
    logic          r_s2_v;
    logic          r_s2_mode;
    logic [DW-1:0] r_s2_d;

    // S2 can take new data when it is empty or is being drained this cycle.
    // S1 moves forward only when it holds something and S2 moves.
    // in_ready therefore depends combinationally on out_ready, so a full
    // pipeline keeps running at one pair per cycle.
    always_comb begin
        w_s2_adv = !r_s2_v || out_ready;
        w_s1_adv = r_s1_v && w_s2_adv;
        in_ready = !r_s1_v || w_s1_adv;
        w_acc    = in_valid && in_ready;
    end

    // Kyber mode zero-extends the low 12 bits. Dilithium uses all AW bits.
    always_comb begin
        w_a = in_mode ? in_a : {{(AW-KW){1'b0}}, in_a[KW-1:0]};
        w_b = in_mode ? in_b : {{(AW-KW){1'b0}}, in_b[KW-1:0]};
    end

`ifdef MRMUL_RANGE_CHK_EN
    localparam logic [AW-1:0] Q_KYBER = AW'(3329);
    localparam logic [AW-1:0] Q_DIL   = AW'(8380417);

    logic          w_err;
    logic [AW-1:0] w_q;
    logic          r_s1_err;
    logic          r_s2_err;

    // Bits that Kyber masking throws away still count as a range violation.
    always_comb begin
        w_q   = in_mode ? Q_DIL : Q_KYBER;
        w_err = (w_a >= w_q) || (w_b >= w_q) ||
                (!in_mode && ((|in_a[AW-1:KW]) || (|in_b[AW-1:KW])));
    end
`endif

    // Stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
`ifdef MRMUL_RANGE_CHK_EN
            r_s1_err  <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_s1_v    <= 1'b1;
                r_s1_mode <= in_mode;
                r_s1_a    <= w_a;
                r_s1_b    <= w_b;
`ifdef MRMUL_RANGE_CHK_EN
                r_s1_err  <= w_err;
`endif
            end else if (w_s1_adv) begin
                r_s1_v    <= 1'b0;
            end
        end
    end

    // Full-width unsigned product of the registered operands
    assign w_prod = DW'(r_s1_a) * DW'(r_s1_b);

    // Stage 2. Data is loaded only when S1 hands something over, so a stalled
    // or emptied stage keeps its last bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_d    <= '0;
`ifdef MRMUL_RANGE_CHK_EN
            r_s2_err  <= 1'b0;
`endif
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_mode <= r_s1_mode;
                r_s2_d    <= w_prod;
`ifdef MRMUL_RANGE_CHK_EN
                r_s2_err  <= r_s1_err;
`endif
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_mode  = r_s2_mode;
    assign out_d     = r_s2_d;
`ifdef MRMUL_RANGE_CHK_EN
    assign out_err   = r_s2_err;
`endif

endmodule

// File: tb/tb_mr_operand_mul.sv
module tb_mr_operand_mul;

    localparam int DW = 46;
    localparam int AW = 23;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [AW-1:0] in_a;
    logic [AW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [DW-1:0] out_d;
    logic          out_err;

    mr_operand_mul #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_d     (out_d)
`ifdef MRMUL_RANGE_CHK_EN
        ,
        .out_err   (out_err)
`endif
    );

`ifndef MRMUL_RANGE_CHK_EN
    assign out_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [63:0]   d;
        logic          err;
    } vec_t;

    typedef struct {
        logic        mode;
        logic [63:0] d;
        logic        err;
    } exp_t;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];
    int   n_acc = 0;
    int   n_out = 0;
    int   cur_run = 0;
    int   max_run = 0;
    int   first_block_acc = -1;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic prev_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: mask to the mode's coefficient width, multiply, and range-check
    // against q using plain integer arithmetic.
    function automatic exp_t model(input logic mode, input logic [AW-1:0] a, input logic [AW-1:0] b);
        exp_t        e;
        longint      ma, mb, q;
        ma     = mode ? longint'(a) : longint'(a) % 4096;
        mb     = mode ? longint'(b) : longint'(b) % 4096;
        q      = mode ? 8380417 : 3329;
        e.mode = mode;
        e.d    = 64'(ma * mb);
        e.err  = (ma >= q) || (mb >= q) || (!mode && (a >= 4096 || b >= 4096));
        return e;
    endfunction

    // One clock with scoreboard bookkeeping. Handshakes are observed at the
    // falling edge, before the rising edge that completes them.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (in_valid && in_ready) begin
            sb.push_back(model(in_mode, in_a, in_b));
            n_acc++;
        end
        if (in_valid && !in_ready && first_block_acc < 0)
            first_block_acc = n_acc;
        if (prev_stall) begin
            chk("stall_d_stable", 64'(out_d), 64'(prev_d));
            chk("stall_mode_stable", 64'(out_mode), 64'(prev_mode));
        end
        if (out_valid && out_ready) begin
            n_out++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_output: got d=0x%0h, expected no output", out_d);
            end else begin
                e = sb.pop_front();
                chk("sb_d", 64'(out_d), e.d);
                chk("sb_mode", 64'(out_mode), 64'(e.mode));
`ifdef MRMUL_RANGE_CHK_EN
                chk("sb_err", 64'(out_err), 64'(e.err));
`endif
            end
        end else begin
            cur_run = 0;
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_d;
        prev_mode  = out_mode;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t vecs[10];
    int   base_acc, base_out, cnt;

    initial begin
        vecs[0] = '{1'b0, 23'd3328,    23'd3328,    64'd11075584,       1'b0};
        vecs[1] = '{1'b1, 23'd8380416, 23'd8380416, 64'd70231372333056, 1'b0};
        vecs[2] = '{1'b0, 23'h7FF001,  23'd2,       64'd2,              1'b1};
        vecs[3] = '{1'b1, 23'd0,       23'd5,       64'd0,              1'b0};
        vecs[4] = '{1'b0, 23'd3329,    23'd1,       64'd3329,           1'b1};
        vecs[5] = '{1'b1, 23'd8380417, 23'd1,       64'd8380417,        1'b1};
        vecs[6] = '{1'b1, 23'h400000,  23'd2,       64'd8388608,        1'b0};
        vecs[7] = '{1'b0, 23'hFFF,     23'hFFF,     64'd16769025,       1'b1};
        vecs[8] = '{1'b1, 23'h7FFFFF,  23'h7FFFFF,  64'd70368727400449, 1'b1};
        vecs[9] = '{1'b0, 23'h1234,    23'hFFF,     64'd2309580,        1'b1};

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_d",     64'(out_d),     64'd0);
        chk("rst_out_mode",  64'(out_mode),  64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Directed vectors, one at a time, checking latency 2
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_mode = vecs[i].mode; in_a = vecs[i].a; in_b = vecs[i].b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_lat1_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_d",     64'(out_d),     vecs[i].d);
            chk("vec_mode",  64'(out_mode),  64'(vecs[i].mode));
`ifdef MRMUL_RANGE_CHK_EN
            chk("vec_err",   64'(out_err),   64'(vecs[i].err));
`endif
            @(posedge clk); #1;
        end

        // Back-pressure: 5 pairs a=i+1, b=3, out_ready low during cycles 2..5
        base_acc = n_acc; base_out = n_out; first_block_acc = -1; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = (n_acc - base_acc) < 5;
            in_mode   = 1'b0;
            in_a      = AW'(n_acc - base_acc + 1);
            in_b      = 23'd3;
            step();
        end
        in_valid = 1'b0;
        chk("bp_block_after_2", 64'(first_block_acc - base_acc), 64'd2);
        chk("bp_out_count", 64'(n_out - base_out), 64'd5);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Full throughput, alternating mode
        out_ready = 1'b1; base_acc = n_acc; base_out = n_out; max_run = 0; cur_run = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_mode = i[0];
            in_a = AW'($urandom); in_b = AW'($urandom);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("tp_accepts", 64'(n_acc - base_acc), 64'd8);
        chk("tp_outputs", 64'(n_out - base_out), 64'd8);
        chk("tp_run_len", 64'(max_run), 64'd8);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b1; in_a = 23'd77; in_b = 23'd11; step();
        in_a = 23'd99; step();
        chk("rs_full_valid", 64'(out_valid), 64'd1);
        chk("rs_full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete(); prev_stall = 1'b0;
        #1;
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b1; in_a = 23'd1000; in_b = 23'd1000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rs_lat1_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("rs_new_valid", 64'(out_valid), 64'd1);
        chk("rs_new_d",     64'(out_d),     64'd1000000);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("rs_no_stale", 64'(cnt), 64'd0);

        // Random traffic against the reference model
        base_acc = n_acc; base_out = n_out; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom % 4) != 0;
                in_mode  = $urandom % 2;
                in_a     = ($urandom % 2) ? AW'($urandom % 3329) : AW'($urandom);
                in_b     = ($urandom % 2) ? AW'($urandom % 8380417) : AW'($urandom);
            end
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rnd_drained", 64'(sb.size()), 64'd0);
        chk("rnd_in_eq_out", 64'(n_out - base_out), 64'(n_acc - base_acc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
